// File: rtl/ether_pkg.sv
// Ethernet/RMII constants shared by the receive (packet_catcher_9k) and
// transmit (packet_blaster_9k) blocks.
package ether_pkg;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam logic [31:0] CRC_POLY       = 32'h04C11DB7;
  localparam logic [31:0] CRC_POLY_REFL  = reflect32(CRC_POLY);
  // Residue in normal bit order; the LSB-first shift register holds it reflected.
  localparam logic [31:0] CRC_RESIDUAL   = 32'hC704DD7B;

  localparam logic [10:0] DST_OFF   = 11'd0;
  localparam logic [10:0] SRC_OFF   = 11'd6;
  localparam logic [10:0] TYPE_OFF  = 11'd12;
  localparam logic [10:0] DATA_OFF  = 11'd14;
  localparam logic [10:0] DATA_END  = 11'd16;
  localparam logic [10:0] MAX_BYTES = 11'd1518;
  localparam logic [10:0] MIN_BYTES = 11'd20;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PREAMBLE  = 2'd1;
  localparam logic [1:0] ST_BODY      = 2'd2;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd3;

endpackage

// File: rtl/crc32_dibit.sv
// Reflected CRC-32 advanced two bits per clock; din_i[0] is the earlier bit.
module crc32_dibit
  import ether_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [1:0]  din_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
    return (c[0] ^ b) ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (init_i)    crc_d = 32'hFFFF_FFFF;
    else if (en_i) crc_d = crc_bit(crc_bit(crc_q, din_i[0]), din_i[1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= 32'h0;
    else     crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/packet_catcher_9k.sv
// RMII receive filter: captures source MAC and first two payload bytes of
// frames addressed to MAC (or broadcast) carrying ETHERTYPE with a good FCS.
module packet_catcher_9k
  import ether_pkg::*;
#(
  parameter logic [47:0] MAC       = 48'h00_00_00_00_00_00,
  parameter logic [15:0] ETHERTYPE = 16'h1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        crsdv,
  input  logic [1:0]  rxd,
  output logic [15:0] data,
  output logic [47:0] src_mac,
  output logic        valid,
  output logic        crc_err
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  phase_q;
  logic [10:0] cnt_q;
  logic [5:0]  sr_q;
  logic [47:0] dst_q, src_q, src_mac_q;
  logic [15:0] type_q, dat_q, data_q;
  logic        valid_q, crc_err_q;
  logic [31:0] crc_w;
  logic [7:0]  byte_w;
  logic        crc_init, crc_en, eval, pass, crc_ok;

  crc32_dibit u_crc (
    .clk    (clk),
    .rst    (rst),
    .init_i (crc_init),
    .en_i   (crc_en),
    .din_i  (rxd),
    .crc_o  (crc_w)
  );

  always_comb begin
    byte_w   = {rxd, sr_q};
    crc_init = (state_q == ST_PREAMBLE) && crsdv && (rxd == SFD_DIBIT);
    crc_en   = (state_q == ST_BODY) && crsdv;
    eval     = (state_q == ST_BODY) && !crsdv;
    pass     = (cnt_q >= MIN_BYTES) && (phase_q == 2'd0) &&
               ((dst_q == MAC) || (dst_q == 48'hFFFF_FFFF_FFFF)) &&
               (type_q == ETHERTYPE);
    crc_ok   = (reflect32(crc_w) == CRC_RESIDUAL);

    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (crsdv) state_d = (rxd == PREAMBLE_DIBIT) ? ST_PREAMBLE : ST_WAIT_IDLE;
      ST_PREAMBLE:
        if (!crsdv)                     state_d = ST_IDLE;
        else if (rxd == SFD_DIBIT)      state_d = ST_BODY;
        else if (rxd != PREAMBLE_DIBIT) state_d = ST_WAIT_IDLE;
      ST_BODY:
        if (!crsdv) state_d = ST_IDLE;
        else if ((phase_q == 2'd3) && (cnt_q == MAX_BYTES - 11'd1)) state_d = ST_WAIT_IDLE;
      default:
        if (!crsdv) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_WAIT_IDLE;
      phase_q   <= 2'd0;
      cnt_q     <= 11'd0;
      sr_q      <= 6'd0;
      dst_q     <= 48'd0;
      src_q     <= 48'd0;
      type_q    <= 16'd0;
      dat_q     <= 16'd0;
      data_q    <= 16'd0;
      src_mac_q <= 48'd0;
      valid_q   <= 1'b0;
      crc_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= eval && pass && crc_ok;
      crc_err_q <= eval && pass && !crc_ok;
      if (eval && pass && crc_ok) begin
        data_q    <= dat_q;
        src_mac_q <= src_q;
      end
      if (crc_init) begin
        phase_q <= 2'd0;
        cnt_q   <= 11'd0;
      end else if (crc_en) begin
        sr_q    <= {rxd, sr_q[5:2]};
        phase_q <= phase_q + 2'd1;
        // Fields shift in MSB-first so the first wire byte lands on top.
        if (phase_q == 2'd3) begin
          cnt_q <= cnt_q + 11'd1;
          if (cnt_q < SRC_OFF)       dst_q  <= {dst_q[39:0], byte_w};
          else if (cnt_q < TYPE_OFF) src_q  <= {src_q[39:0], byte_w};
          else if (cnt_q < DATA_OFF) type_q <= {type_q[7:0], byte_w};
          else if (cnt_q < DATA_END) dat_q  <= {dat_q[7:0], byte_w};
        end
      end
    end
  end

  assign data    = data_q;
  assign src_mac = src_mac_q;
  assign valid   = valid_q;
  assign crc_err = crc_err_q;

endmodule

// File: doc/packet_catcher_9k.md
PACKET_CATCHER_9K -- requirements
Module: packet_catcher_9k

Interface
REQ-001 SHALL have parameter MAC, default 48'h00_00_00_00_00_00 (overridden per board): station address accepted as destination.
REQ-002 SHALL have parameter ETHERTYPE, default 16'h1234: length/type value accepted.
REQ-003 clk  in  1  50 MHz RMII reference clock; sole clock; one dibit per cycle.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 crsdv  in  1  RMII carrier-sense/data-valid.
REQ-006 rxd  in  2  RMII receive dibit; LSB-first within each byte.
REQ-007 data  out  16  first two payload bytes; first byte on wire in [15:8].
REQ-008 src_mac  out  48  source MAC of last accepted frame; first byte on wire in [47:40].
REQ-009 valid  out  1  one-cycle pulse on acceptance of a good frame.
REQ-010 crc_err  out  1  one-cycle pulse when an otherwise acceptable frame fails FCS.

Function
REQ-011 States: IDLE, PREAMBLE, BODY, WAIT_IDLE; state and all outputs update only on clk rising edge.
REQ-012 IDLE: crsdv=1 with rxd=2'b01 -> PREAMBLE; crsdv=1 with any other dibit -> WAIT_IDLE.
REQ-013 PREAMBLE: rxd=2'b01 stays; rxd=2'b11 (SFD tail) -> BODY with dibit and byte counters cleared and CRC seeded to 32'hFFFFFFFF; any other dibit -> WAIT_IDLE; crsdv=0 -> IDLE.
REQ-014 BODY: assemble bytes from 4 dibits, first dibit into bits [1:0]; feed every dibit to CRC.
REQ-015 Byte offsets after SFD: 0-5 dst, 6-11 src, 12-13 type (big-endian), 14-15 data, then pad, final 4 FCS.
REQ-016 Byte counter 11 bits; on reaching 1518 bytes -> WAIT_IDLE with no pulse.
REQ-017 BODY exits on first cycle crsdv=0, evaluated: bytes >= 20, dibit phase 0, dst == MAC or 48'hFFFFFFFFFFFF, type == ETHERTYPE.
REQ-018 Evaluation pass and CRC residual == 32'hC704DD7B -> valid=1 next cycle, data/src_mac updated same edge.
REQ-019 Evaluation pass and residual mismatch -> crc_err=1 next cycle; data/src_mac unchanged.
REQ-020 Evaluation fail (runt, partial byte, dst/type mismatch) -> no pulse, outputs unchanged.
REQ-021 valid and crc_err never high together; each high at most one cycle per frame.
REQ-022 data/src_mac hold until next valid.
REQ-023 WAIT_IDLE: remain until crsdv=0, then IDLE; no pulses emitted.
REQ-024 Latency: pulse visible the cycle after the edge sampling first crsdv=0 of the frame.
REQ-025 Back-to-back frames: IDLE re-armed same edge as exit; a frame starting the next cycle is accepted.

Reset
REQ-026 rst=1 asynchronously forces state WAIT_IDLE, data=0, src_mac=0, valid=0, crc_err=0, counters and CRC cleared.
REQ-027 Frame in progress at reset release is discarded; capture resumes only after crsdv=0 seen.

Structure
REQ-028 Shared package ether_pkg holds PREAMBLE_DIBIT, SFD_DIBIT, CRC_RESIDUAL, CRC_POLY, field byte offsets, MAX_BYTES, MIN_BYTES, state encoding; shared with packet_blaster_9k.
REQ-029 One sub-module crc32_dibit: reflected CRC-32 (poly 32'h04C11DB7), 2 bits/cycle, init/enable inputs, 32-bit state out.

Verification
REQ-030 dst=MAC, src=00:11:22:33:44:55, type 0x1234, data 0xBEEF, 44 zero pad, good FCS -> one valid, data=16'hBEEF, src_mac=48'h001122334455.
REQ-031 Same frame, one FCS bit flipped -> one crc_err, no valid, data unchanged.
REQ-032 dst=02:00:00:00:00:99 (non-broadcast, != MAC) -> no pulses; broadcast dst with good FCS -> valid.
REQ-033 crsdv dropped after 10 body bytes -> no pulses; following good frame -> valid.
REQ-034 rst pulsed at body byte 8, released mid-frame -> that frame yields no pulse; next good frame (0xCAFE) -> valid, data=16'hCAFE.
REQ-035 Two good frames, 12-byte gap, data 0x0001 then 0x0002 -> two valid pulses, data 0x0001 then 0x0002.
